// File: rtl/dma_k_req_sched_pkg.sv
// Shared types and constants for the DMA tile-request scheduler.
// State encoding plus the lane-bytes helper used to size the per-issue shift.
package dma_k_req_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CALC   = 3'd1,
    ST_ISSUE  = 3'd2,
    ST_SETTLE = 3'd3,
    ST_WAIT   = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  // Bytes consumed by one issue beat across all lanes.
  function automatic int lane_bytes(input int out_data_width, input int issue_num);
    return (out_data_width / 8) * issue_num;
  endfunction

  localparam int LANE_BYTES_DEFAULT = lane_bytes(16, 4);

endpackage

// File: rtl/dma_k_req_sched.sv
// Splits a DMA job descriptor into tile requests for a downstream issue stage.
// Optional macro DMA_K_REQ_SCHED_PERF_EN adds the stall_cycles counter output.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
// The side raising valid holds it and its payload stable until that transfer;
// the ready side may change ready freely.
module dma_k_req_sched
  import dma_k_req_sched_pkg::*;
#(
  parameter int ISSUE_NUM      = 4,
  parameter int OUT_DATA_WIDTH = 16,
  parameter int MAX_TILE_BYTES = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        job_valid,
  output logic        job_ready,
  input  logic [31:0] job_base_addr,
  input  logic [31:0] job_total_bytes,
  input  logic [31:0] job_tile_bytes,
  output logic        req_valid,
  input  logic        req_ready,
  output logic [31:0] req_base_addr,
  output logic [31:0] req_legal_lenth,
  output logic [31:0] req_per_issue_num,
  output logic        busy,
  output logic        job_done,
  output logic [15:0] tile_count,
  output state_t      fsm_state
`ifdef DMA_K_REQ_SCHED_PERF_EN
  ,
  output logic [31:0] stall_cycles
`endif
);

  localparam int LANE_BYTES = lane_bytes(OUT_DATA_WIDTH, ISSUE_NUM);
  localparam int LANE_SHIFT = $clog2(LANE_BYTES);

  if (LANE_BYTES <= 0 || (LANE_BYTES & (LANE_BYTES - 1)) != 0) begin : g_lane_check
    $error("dma_k_req_sched: lane bytes must be a power of two");
  end

  state_t      state, state_d;
  logic [31:0] rem_q, tile_q;
  logic [31:0] tile_len_c, per_issue_c;
  logic        accept, handshake;

  assign accept    = (state == ST_IDLE) && job_valid;
  assign handshake = (state == ST_ISSUE) && req_ready;

  always_comb begin
    tile_len_c  = (tile_q < rem_q) ? tile_q : rem_q;
    // Rounded-up division by the lane bytes, done as add-then-shift.
    per_issue_c = 32'((33'(tile_len_c) + 33'(LANE_BYTES - 1)) >> LANE_SHIFT);
  end

  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE:   if (job_valid) state_d = ST_CALC;
      ST_CALC:   state_d = (rem_q == 32'd0) ? ST_DONE : ST_ISSUE;
      ST_ISSUE:  if (req_ready) state_d = ST_SETTLE;
      ST_SETTLE: state_d = ST_WAIT;
      ST_WAIT:   if (req_ready) state_d = ST_CALC;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= ST_IDLE;
      rem_q             <= '0;
      tile_q            <= '0;
      req_base_addr     <= '0;
      req_legal_lenth   <= '0;
      req_per_issue_num <= '0;
      tile_count        <= '0;
    end else begin
      state <= state_d;
      if (accept) begin
        req_base_addr <= job_base_addr;
        rem_q         <= job_total_bytes;
        tile_q        <= (job_tile_bytes == 32'd0) ? 32'(MAX_TILE_BYTES) : job_tile_bytes;
        tile_count    <= '0;
      end
      if (state == ST_CALC && rem_q != 32'd0) begin
        req_legal_lenth   <= tile_len_c;
        req_per_issue_num <= per_issue_c;
      end
      if (handshake) begin
        req_base_addr <= req_base_addr + req_legal_lenth;
        rem_q         <= rem_q - req_legal_lenth;
        if (tile_count != 16'hFFFF) tile_count <= tile_count + 16'd1;
      end
    end
  end

`ifdef DMA_K_REQ_SCHED_PERF_EN
  always_ff @(posedge clk) begin
    if (rst || accept) begin
      stall_cycles <= '0;
    end else if ((state == ST_ISSUE && !req_ready) || state == ST_WAIT) begin
      if (stall_cycles != 32'hFFFF_FFFF) stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

  assign job_ready = (state == ST_IDLE);
  assign req_valid = (state == ST_ISSUE);
  assign busy      = (state != ST_IDLE);
  assign job_done  = (state == ST_DONE);
  assign fsm_state = state;

endmodule

// File: tb/tb_dma_k_req_sched.sv
// Randomized bench for dma_k_req_sched against a tile-list reference model.
module tb_dma_k_req_sched;
  import dma_k_req_sched_pkg::*;

  localparam int LANE_BYTES = 8;
  localparam int DEF_TILE   = 4096;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        job_valid = 1'b0;
  logic        job_ready;
  logic [31:0] job_base_addr = '0;
  logic [31:0] job_total_bytes = '0;
  logic [31:0] job_tile_bytes = '0;
  logic        req_valid;
  logic        req_ready = 1'b1;
  logic [31:0] req_base_addr, req_legal_lenth, req_per_issue_num;
  logic        busy, job_done;
  logic [15:0] tile_count;
  state_t      fsm_state;
`ifdef DMA_K_REQ_SCHED_PERF_EN
  logic [31:0] stall_cycles;
`endif

  dma_k_req_sched dut (
    .clk(clk), .rst(rst),
    .job_valid(job_valid), .job_ready(job_ready),
    .job_base_addr(job_base_addr), .job_total_bytes(job_total_bytes),
    .job_tile_bytes(job_tile_bytes),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_base_addr(req_base_addr), .req_legal_lenth(req_legal_lenth),
    .req_per_issue_num(req_per_issue_num),
    .busy(busy), .job_done(job_done), .tile_count(tile_count),
    .fsm_state(fsm_state)
`ifdef DMA_K_REQ_SCHED_PERF_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Scoreboard: expected request stream and per-job tile counts
  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_len_q[$];
  logic [31:0] exp_pi_q[$];
  logic [31:0] exp_tc_q[$];
  int exp_done = 0;
  int done_cnt = 0;

  // Issue-stage model state
  int          hold = 0;
  int          stall_left = 0;
  logic        prev_pending = 1'b0;
  logic [31:0] prev_addr, prev_len, prev_pi;

  always @(negedge clk) begin
    logic [31:0] e;
    if (rst) begin
      req_ready    = 1'b1;
      hold         = 0;
      prev_pending = 1'b0;
    end else begin
      if (hold > 0) begin
        req_ready = 1'b0;
        hold--;
      end else if (stall_left > 0 && req_valid) begin
        req_ready = 1'b0;
        stall_left--;
      end else begin
        req_ready = ($urandom_range(0, 3) != 0);
      end
      check("job_ready_vs_busy", job_ready, !busy);
      if (prev_pending && req_valid) begin
        check("stable_addr", req_base_addr, prev_addr);
        check("stable_len", req_legal_lenth, prev_len);
        check("stable_pi", req_per_issue_num, prev_pi);
      end
      if (req_valid && req_ready) begin
        if (exp_addr_q.size() == 0) begin
          check("unexpected_req", 32'd1, 32'd0);
        end else begin
          e = exp_addr_q.pop_front(); check("req_addr", req_base_addr, e);
          e = exp_len_q.pop_front();  check("req_len", req_legal_lenth, e);
          e = exp_pi_q.pop_front();   check("req_per_issue", req_per_issue_num, e);
        end
        hold = $urandom_range(1, 3);
        prev_pending = 1'b0;
      end else begin
        prev_pending = req_valid;
        prev_addr = req_base_addr;
        prev_len  = req_legal_lenth;
        prev_pi   = req_per_issue_num;
      end
      if (job_done) begin
        done_cnt++;
        if (exp_tc_q.size() == 0) begin
          check("spurious_done", 32'd1, 32'd0);
        end else begin
          e = exp_tc_q.pop_front();
          check("tile_count", {16'd0, tile_count}, e);
        end
      end
    end
  end

  // Reference model: expand the descriptor into its tile list, then present it.
  task automatic submit(input logic [31:0] b, input logic [31:0] t, input logic [31:0] ti);
    logic [31:0] a, rem, tl, len;
    int n;
    bit accepted;
    a = b; rem = t; tl = (ti == 0) ? DEF_TILE : ti; n = 0;
    while (rem != 0) begin
      len = (tl < rem) ? tl : rem;
      exp_addr_q.push_back(a);
      exp_len_q.push_back(len);
      exp_pi_q.push_back(32'((64'(len) + LANE_BYTES - 1) / LANE_BYTES));
      a = a + len;
      rem = rem - len;
      n++;
    end
    exp_tc_q.push_back((n > 65535) ? 32'd65535 : 32'(n));
    exp_done++;
    @(negedge clk);
    job_base_addr = b; job_total_bytes = t; job_tile_bytes = ti;
    job_valid = 1'b1;
    accepted = 0;
    for (int i = 0; i < 20000 && !accepted; i++) begin
      if (job_ready) accepted = 1;
      else @(negedge clk);
    end
    if (!accepted) begin
      check("accept_timeout", 32'd0, 32'd1);
      job_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 job_valid = 1'b0;
    @(negedge clk);
    check("lat_calc_valid", req_valid, 1'b0);
    check("lat_calc_done", job_done, 1'b0);
    @(negedge clk);
    if (t == 0) check("lat_zero_done", job_done, 1'b1);
    else        check("lat_first_valid", req_valid, 1'b1);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int i = 0; i < 20000 && !ok; i++) begin
      @(negedge clk);
      if (!busy) ok = 1;
    end
    if (!ok) check("idle_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] b, t, ti;
    bit seen;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_req_valid", req_valid, 1'b0);
    check("rst_job_ready", job_ready, 1'b1);
    check("rst_tile_count", {16'd0, tile_count}, 32'd0);
    check("rst_req_addr", req_base_addr, 32'd0);
    check("rst_job_done", job_done, 1'b0);
    rst = 1'b0;

    submit(32'h0000_1000, 32'd8192, 32'd4096); wait_idle();
    submit(32'h0000_2000, 32'd100, 32'd64);    wait_idle();
    submit(32'h0000_3000, 32'd0, 32'd64);      wait_idle();
    submit(32'h0000_4000, 32'd5000, 32'd0);    wait_idle();
    submit(32'hFFFF_FFC0, 32'd200, 32'd64);    wait_idle();

    stall_left = 10;
    submit(32'h0001_0000, 32'd1024, 32'd512);  wait_idle();
`ifdef DMA_K_REQ_SCHED_PERF_EN
    check("perf_stall_ge10", 32'(stall_cycles >= 10), 32'd1);
`endif

    // Second job presented while the first is running must be held off.
    submit(32'h0002_0000, 32'd300, 32'd100);
    submit(32'h0003_0000, 32'd50, 32'd16);
    wait_idle();

    for (int i = 0; i < 8; i++) begin
      b = $urandom;
      t = $urandom_range(0, 2500);
      case ($urandom_range(0, 3))
        0:       ti = 0;
        1:       ti = $urandom_range(16, 64);
        default: ti = $urandom_range(65, 1500);
      endcase
      submit(b, t, ti);
      wait_idle();
    end

    // Reset while waiting for the issue stage to go idle again.
    submit(32'h0004_0000, 32'd8192, 32'd4096);
    seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      if (fsm_state == ST_WAIT) seen = 1;
      else @(negedge clk);
    end
    check("reach_wait", 32'(seen), 32'd1);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1 rst = 1'b0;
    check("wrst_state", 32'(fsm_state), 32'(ST_IDLE));
    check("wrst_busy", busy, 1'b0);
    check("wrst_job_ready", job_ready, 1'b1);
    check("wrst_req_valid", req_valid, 1'b0);
    check("wrst_job_done", job_done, 1'b0);
    check("wrst_tile_count", {16'd0, tile_count}, 32'd0);
    check("wrst_req_len", req_legal_lenth, 32'd0);
    exp_addr_q.delete();
    exp_len_q.delete();
    exp_pi_q.delete();
    exp_tc_q.delete();
    exp_done--;
    repeat (5) @(negedge clk);

    submit(32'h0005_0000, 32'd64, 32'd0);
    wait_idle();
    repeat (3) @(negedge clk);

    check("exp_req_drained", 32'(exp_addr_q.size()), 32'd0);
    check("exp_tc_drained", 32'(exp_tc_q.size()), 32'd0);
    check("done_count", 32'(done_cnt), 32'(exp_done));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dma_k_req_sched.md
DMA_K_REQ_SCHED -- requirements
Module: dma_k_req_sched

Interface
REQ-001 SHALL have parameter ISSUE_NUM, default 4: number of issue lanes in the downstream issue stage.
REQ-002 SHALL have parameter OUT_DATA_WIDTH, default 16: lane element width in bits.
REQ-003 SHALL have parameter MAX_TILE_BYTES, default 4096: tile size used when job_tile_bytes is 0.
REQ-004 SHALL have port clk  input  1: the only clock; one clock, all logic on its rising edge.
REQ-005 SHALL have port rst  input  1: reset, synchronous and active-high.
REQ-006 SHALL have ports job_valid input 1 / job_ready output 1: job descriptor handshake.
REQ-007 SHALL have ports job_base_addr, job_total_bytes, job_tile_bytes: each input, 32 bits; byte address, byte length, tile size.
REQ-008 SHALL have ports req_valid output 1 / req_ready input 1: tile request handshake toward the issue stage.
REQ-009 SHALL have ports req_base_addr, req_legal_lenth, req_per_issue_num: each output, 32 bits; tile address, tile bytes, issue count.
REQ-010 SHALL have ports busy output 1, job_done output 1 (one-cycle pulse), tile_count output 16 (tiles issued in current or last job).

Function
REQ-011 SHALL implement states IDLE, CALC, ISSUE, SETTLE, WAIT, DONE.
REQ-012 IDLE: job_ready=1; on job_valid&job_ready, latch the descriptor, clear tile_count and go to CALC.
REQ-013 Latched tile size SHALL be MAX_TILE_BYTES if job_tile_bytes==0, else job_tile_bytes.
REQ-014 CALC: if remaining==0 go to DONE without any request; else tile_len=min(tile, remaining) and go to ISSUE.
REQ-015 CALC SHALL compute req_per_issue_num = ceil(tile_len / (OUT_DATA_WIDTH/8*ISSUE_NUM)) using a shift; this divisor SHALL be a power of two (elaboration error otherwise).
REQ-016 ISSUE: req_valid=1; outputs stable until req_valid&req_ready; then add tile_len to the address, subtract it from remaining, increment tile_count, go to SETTLE.
REQ-017 SETTLE: one cycle, req_ready ignored (the issue stage drops ready the cycle after accept); go to WAIT.
REQ-018 WAIT: on req_ready==1 (issue stage idle again) go to CALC.
REQ-019 DONE: job_done=1 for exactly one cycle, then IDLE.
REQ-020 busy SHALL be 1 in every state except IDLE.
REQ-021 Address addition SHALL wrap modulo 2^32 without error; tile_count SHALL saturate at 0xFFFF.
REQ-022 job_ready=0 outside IDLE; a job presented while busy SHALL be held off, not dropped.
REQ-023 The first req_valid SHALL assert 2 cycles after job acceptance (IDLE->CALC->ISSUE).

Reset
REQ-024 rst SHALL force IDLE, req_valid=0, job_done=0, busy=0, tile_count=0, all request outputs 0, in any state, including mid-handshake.

Configuration
REQ-025 Macro DMA_K_REQ_SCHED_PERF_EN SHALL, when defined, add output stall_cycles (32 bits): counts cycles in ISSUE with req_ready=0 plus cycles in WAIT; cleared on job accept; saturating.
REQ-026 Without DMA_K_REQ_SCHED_PERF_EN the port and counter SHALL be absent; all other behaviour identical.

Structure
REQ-027 State enum and the lane-bytes constant SHALL live in the shared package of the calc kernel.
REQ-028 SHALL be a single flat module; no sub-module.

Verification
REQ-029 job base 0x1000, total 8192, tile 4096, ready always 1 except 1..3 cycles after accept -> two requests at 0x1000/0x2000, len 4096, per_issue 512; tile_count=2; one job_done.
REQ-030 total 100, tile 64 -> requests len 64 (per_issue 8), then len 36 at base+64 (per_issue 5).
REQ-031 total 0 -> no req_valid; job_done 2 cycles after accept.
REQ-032 tile 0, total 5000 -> lengths 4096 then 904.
REQ-033 req_ready held 0 for 10 cycles in ISSUE -> request fields stable; with PERF_EN, stall_cycles>=10.
REQ-034 rst asserted in WAIT -> next cycle IDLE, busy=0, job_ready=1, no job_done pulse.
